// File: rtl/filter_scheduler.sv
// filter_scheduler: per-channel hysteresis debounce on a programmable sample
// tick. Level changes are arbitrated round-robin into a small event FIFO.
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   data_in[CH]       pre-synchronised raw inputs
//   cfg_we            single-cycle config load strobe
//   cfg_presc         sample period minus 1
//   cfg_n             counter saturation value
//   cfg_bound         hysteresis high threshold
//   cfg_err           sticky: last cfg_we was rejected
//   level_out[CH]     filtered levels
//   evt_valid/ready   event FIFO head handshake
//   evt_ch, evt_rise  head event: channel and direction (1 = rising)
//   overflow[CH]      sticky per-channel lost-edge flags
module filter_scheduler #(
  parameter int unsigned CH    = 4,
  parameter int unsigned WD    = 3,
  parameter int unsigned PW    = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [CH-1:0]          data_in,
  input  logic                   cfg_we,
  input  logic [PW-1:0]          cfg_presc,
  input  logic [WD-1:0]          cfg_n,
  input  logic [WD-1:0]          cfg_bound,
  output logic                   cfg_err,
  output logic [CH-1:0]          level_out,
  output logic                   evt_valid,
  input  logic                   evt_ready,
  output logic [$clog2(CH)-1:0]  evt_ch,
  output logic                   evt_rise,
  output logic [CH-1:0]          overflow
);

  localparam int unsigned CHW = $clog2(CH);
  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned CW  = AW + 1;

  typedef struct packed {
    logic [CHW-1:0] ch;
    logic           rise;
  } evt_t;

  // Registered state
  logic [PW-1:0]  presc_q, pcnt_q;
  logic [WD-1:0]  n_q, bound_q;
  logic [WD-1:0]  cnt_q [CH];
  logic [CH-1:0]  pending_q, dir_q;
  logic [CHW-1:0] rr_q;
  evt_t           mem_q [DEPTH];
  logic [AW-1:0]  wr_q, rd_q;
  logic [CW-1:0]  count_q;

  // Next-state values
  logic [PW-1:0]  presc_nx, pcnt_nx;
  logic [WD-1:0]  n_nx, bound_nx;
  logic           err_nx;
  logic [WD-1:0]  cnt_upd [CH];
  logic [WD-1:0]  cnt_nx  [CH];
  logic [CH-1:0]  lvl_upd, lvl_nx, pend_nx, dir_nx, ovf_nx;
  logic [CHW-1:0] rr_nx;
  logic [AW-1:0]  wr_nx, rd_nx;
  logic [CW-1:0]  count_nx;
  logic           vld_nx;
  evt_t           head_nx, push_d;

  // Combinational helpers
  logic           cfg_ok_c, cfg_acc_c, tick_c;
  logic [WD-1:0]  lo_thr_c;
  logic [CH-1:0]  chg_c, gnt_oh_c;
  logic [CHW-1:0] gnt_idx_c, arb_idx_c;
  logic           gnt_hit_c, full_c, push_c, pop_c;

  // Config validity: bound <= n and the two hysteresis regions do not overlap
  assign cfg_ok_c  = (cfg_bound <= cfg_n) &&
                     ({1'b0, cfg_bound} > ({1'b0, cfg_n} - {1'b0, cfg_bound}));
  assign cfg_acc_c = cfg_we && cfg_ok_c;
  // A config strobe swallows the tick of the same cycle
  assign tick_c    = !cfg_we && (pcnt_q == presc_q);
  assign lo_thr_c  = n_q - bound_q;

  // Saturating debounce counters and hysteresis level per channel
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      cnt_upd[i] = cnt_q[i];
      lvl_upd[i] = level_out[i];
      if (tick_c) begin
        if (data_in[i] && (cnt_q[i] < n_q))
          cnt_upd[i] = cnt_q[i] + WD'(1);
        else if (!data_in[i] && (cnt_q[i] != '0))
          cnt_upd[i] = cnt_q[i] - WD'(1);
        if (cnt_upd[i] <= lo_thr_c)
          lvl_upd[i] = 1'b0;
        else if (cnt_upd[i] >= bound_q)
          lvl_upd[i] = 1'b1;
      end
    end
  end

  assign chg_c = lvl_upd ^ level_out;

  // Round-robin search: first pending channel at or after rr_q
  always_comb begin
    gnt_hit_c = 1'b0;
    gnt_idx_c = '0;
    arb_idx_c = '0;
    for (int k = 0; k < CH; k++) begin
      arb_idx_c = rr_q + CHW'(k);
      if (!gnt_hit_c && pending_q[arb_idx_c]) begin
        gnt_hit_c = 1'b1;
        gnt_idx_c = arb_idx_c;
      end
    end
  end

  assign full_c   = (count_q == CW'(DEPTH));
  assign push_c   = gnt_hit_c && !full_c && !cfg_acc_c;
  assign pop_c    = evt_valid && evt_ready;
  assign gnt_oh_c = push_c ? (CH'(1) << gnt_idx_c) : '0;
  assign push_d   = '{ch: gnt_idx_c, rise: dir_q[gnt_idx_c]};

  // Control next-state: prescaler, config, pending/dir/overflow, rr pointer
  always_comb begin
    presc_nx = presc_q;
    n_nx     = n_q;
    bound_nx = bound_q;
    err_nx   = cfg_err;
    cnt_nx   = cnt_upd;
    lvl_nx   = lvl_upd;
    pend_nx  = (pending_q & ~gnt_oh_c) | chg_c;
    ovf_nx   = overflow | (chg_c & pending_q & ~gnt_oh_c);
    dir_nx   = dir_q;
    rr_nx    = push_c ? (gnt_idx_c + CHW'(1)) : rr_q;
    for (int i = 0; i < CH; i++)
      if (chg_c[i]) dir_nx[i] = lvl_upd[i];

    if (cfg_we)
      pcnt_nx = pcnt_q;
    else if (pcnt_q == presc_q)
      pcnt_nx = '0;
    else
      pcnt_nx = pcnt_q + PW'(1);

    if (cfg_we) begin
      if (cfg_ok_c) begin
        presc_nx = cfg_presc;
        n_nx     = cfg_n;
        bound_nx = cfg_bound;
        err_nx   = 1'b0;
        pcnt_nx  = '0;
        lvl_nx   = '0;
        pend_nx  = '0;
        dir_nx   = '0;
        ovf_nx   = '0;
        rr_nx    = '0;
        for (int i = 0; i < CH; i++) cnt_nx[i] = '0;
      end else begin
        err_nx = 1'b1;
      end
    end
  end

  // FIFO pointers and registered head
  always_comb begin
    rd_nx    = rd_q + AW'(pop_c);
    wr_nx    = wr_q + AW'(push_c);
    count_nx = count_q + CW'(push_c) - CW'(pop_c);
    vld_nx   = (count_nx != '0);
    // Head bypass when the new head is the entry being written this cycle
    if (push_c && (wr_q == rd_nx))
      head_nx = push_d;
    else
      head_nx = mem_q[rd_nx];
    if (!vld_nx)
      head_nx = '{ch: evt_ch, rise: evt_rise};
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q   <= '0;
      n_q       <= WD'(7);
      bound_q   <= WD'(5);
      cfg_err   <= 1'b0;
      pcnt_q    <= '0;
      level_out <= '0;
      pending_q <= '0;
      dir_q     <= '0;
      overflow  <= '0;
      rr_q      <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      count_q   <= '0;
      evt_valid <= 1'b0;
      evt_ch    <= '0;
      evt_rise  <= 1'b0;
      for (int i = 0; i < CH; i++)    cnt_q[i] <= '0;
      for (int j = 0; j < DEPTH; j++) mem_q[j] <= '0;
    end else begin
      presc_q   <= presc_nx;
      n_q       <= n_nx;
      bound_q   <= bound_nx;
      cfg_err   <= err_nx;
      pcnt_q    <= pcnt_nx;
      level_out <= lvl_nx;
      pending_q <= pend_nx;
      dir_q     <= dir_nx;
      overflow  <= ovf_nx;
      rr_q      <= rr_nx;
      wr_q      <= wr_nx;
      rd_q      <= rd_nx;
      count_q   <= count_nx;
      evt_valid <= vld_nx;
      evt_ch    <= head_nx.ch;
      evt_rise  <= head_nx.rise;
      for (int i = 0; i < CH; i++) cnt_q[i] <= cnt_nx[i];
      if (push_c) mem_q[wr_q] <= push_d;
    end
  end

endmodule

// File: doc/filter_scheduler.md
Name: filter_scheduler

Overview:
- Multi-channel input-conditioning controller for the FPGA controller's external I/O lines (trigger, start, mode straps).
- Generates a programmable sample tick and runs a hysteresis debounce counter per channel on that tick.
- Arbitrates simultaneous level changes round-robin into a small event FIFO, which the command FSM drains with a valid/ready handshake.
- Thresholds and sample rate are runtime-configurable; invalid configurations are rejected.

Parameters:
CH, 4, number of input channels (power of 2, ≥2)
WD, 3, debounce counter width
PW, 8, prescaler width
DEPTH, 4, event FIFO depth (power of 2)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
data_in  in  CH  raw asynchronous inputs; external 2-FF synchroniser precedes this block
cfg_we  in  1  single-cycle config load strobe
cfg_presc  in  PW  sample period minus 1
cfg_n  in  WD  counter saturation value
cfg_bound  in  WD  hysteresis high threshold
cfg_err  out  1  sticky: last cfg_we was rejected
level_out  out  CH  filtered levels
evt_valid  out  1  FIFO head valid
evt_ready  in  1  consumer accepts head
evt_ch  out  log2(CH)  channel of head event
evt_rise  out  1  1 = rising edge, 0 = falling edge
overflow  out  CH  sticky per-channel lost-edge flags

Behaviour:
- Reset values:
  - Config registers: presc = 0, n = 7, bound = 5.
  - Counters, level_out, pending, overflow, cfg_err, prescaler, RR pointer and FIFO pointers all 0.
  - evt_valid = 0; evt_ch = 0; evt_rise = 0.
- Prescaler:
  - Counts 0..presc; tick asserts for 1 cycle when count == presc, then count returns to 0.
  - presc = 0 gives a tick every cycle.
- Per-channel update on tick (all channels in parallel):
  - data_in = 1 and cnt < n: cnt + 1.
  - data_in = 0 and cnt > 0: cnt − 1.
  - Otherwise hold. Arithmetic is WD bits; no wrap, because saturation is guaranteed by the compares.
- Level update, evaluated on the next count value and registered on the same edge as the count:
  - next_cnt ≤ n − bound: level 0.
  - next_cnt ≥ bound: level 1.
  - Otherwise hold.
- Edge detection:
  - If the registered level differs from the old level, set pending[ch] and dir[ch] = new level on that edge.
  - Latency: input sampled at tick cycle t; level_out and pending change at t+1.
- Arbiter:
  - Each cycle, if any pending bit is set and the FIFO is not full, grant the first pending channel at or after rr_ptr (wrapping), push {ch, dir}, clear that pending bit, and set rr_ptr = grant + 1 mod CH.
  - At most one push per cycle. If the FIFO is full, pending bits hold and no push occurs, even when a pop happens in the same cycle.
  - A pushed event is visible on evt_* the cycle after the push (earliest t+2 from sampling).
- Overflow:
  - New edge on a channel whose pending bit is set and which is not granted this cycle: overflow[ch] ← 1, dir[ch] overwritten with the new level, pending stays 1.
  - New edge on a channel in the same cycle it is granted: the old event is pushed, pending is set again with the new dir, no overflow.
- FIFO:
  - Pop when evt_valid && evt_ready.
  - Simultaneous push and pop (not full) keeps the occupancy unchanged.
  - evt_ch and evt_rise reflect the head and must be stable while evt_valid && !evt_ready.
- Configuration (cfg_we):
  - Accepted when cfg_bound ≤ cfg_n and cfg_bound > cfg_n − cfg_bound.
  - On accept: load registers, clear cfg_err, counters, level_out, pending, overflow, prescaler and rr_ptr. The FIFO is not flushed.
  - On reject: set cfg_err and leave all other state untouched.
  - cfg_we has priority over a tick in the same cycle; that tick is dropped.
- Reset mid-operation: all state returns to reset values immediately and asynchronously, including the FIFO. Reset deassertion is synchronised externally.

Test Plan:
- Defaults, presc = 0, data_in[0] held at 1 → cnt reaches 5 on the 5th tick; level_out[0] = 1 at cycle 6; one event {ch0, rise = 1} with evt_valid at cycle 7.
- Glitch on ch1 (1 for 3 ticks, then 0) → level_out[1] stays 0; no event; cnt returns to 0.
- Channels 0–3 rise on the same tick, evt_ready = 1 → events pop in order ch0, ch1, ch2, ch3 on consecutive cycles; rr_ptr = 0 afterwards.
- evt_ready = 0 with 4 events queued, then ch2 falls twice → FIFO stays full, overflow[2] = 1, pending dir = latest level; after draining, ch2 event delivered once.
- cfg_presc = 3, n = 3, bound = 2 → ticks every 4 cycles; a rise needs 2 ticks; cfg n = 3, bound = 1 → cfg_err = 1 and old config retained.
- Assert rst_n low while events are queued → evt_valid, level_out and overflow are all 0 in the same cycle.
